// File: rtl/lstm_gate_mac.sv
// LSTM gate pre-activation MAC: z = bias + sum(x*w), rounded half-up to Q5.5.
// Define LSTM_GATE_MAC_SAT_EN to clamp the result; otherwise it wraps to bit_size bits.
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting x/w beats
// ROUND | round, clamp or wrap, and register gate_out
// DONE  | one-cycle done strobe
module lstm_gate_mac #(
    parameter int bit_size  = 10,
    parameter int frac_bits = 5,
    parameter int vec_len   = 8,
    parameter int acc_size  = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [bit_size-1:0] bias,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bit_size-1:0] x_in,
    input  logic [bit_size-1:0] w_in,
    output logic                busy,
    output logic [bit_size-1:0] gate_out,
    output logic                done
);

    localparam int CNT_W = $clog2(vec_len + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(vec_len - 1);
    localparam logic signed [acc_size-1:0] HALF = acc_size'(1) <<< (frac_bits - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ROUND, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic signed [acc_size-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [bit_size-1:0]         gate_q, gate_d;
    logic signed [2*bit_size-1:0] prod;
    logic [bit_size-1:0]         rnd_res;

    assign prod = $signed(x_in) * $signed(w_in);

`ifdef LSTM_GATE_MAC_SAT_EN
    localparam logic signed [acc_size-1:0] SAT_MAX = acc_size'(2**(bit_size-1) - 1);
    localparam logic signed [acc_size-1:0] SAT_MIN = -acc_size'(2**(bit_size-1));
    logic signed [acc_size-1:0] rnd;

    always_comb begin
        rnd = (acc_q + HALF) >>> frac_bits;
        if (rnd > SAT_MAX)
            rnd_res = SAT_MAX[bit_size-1:0];
        else if (rnd < SAT_MIN)
            rnd_res = SAT_MIN[bit_size-1:0];
        else
            rnd_res = rnd[bit_size-1:0];
    end
`else
    // Two's-complement wrap: keep only the low bit_size bits of the rounded sum.
    assign rnd_res = bit_size'((acc_q + HALF) >>> frac_bits);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            gate_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        gate_d  = gate_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    acc_d   = acc_size'($signed(bias)) <<< frac_bits;
                    cnt_d   = '0;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_q + acc_size'(prod);
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == LAST)
                        state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                gate_d  = rnd_res;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready = (state_q == S_ACCUM);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign gate_out = gate_q;

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Scoreboard bench for lstm_gate_mac: directed vectors with hand-computed results.
// Expected overflow results follow LSTM_GATE_MAC_SAT_EN.
module tb_lstm_gate_mac;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] bias;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] x_in;
    logic [9:0] w_in;
    logic       busy;
    logic [9:0] gate_out;
    logic       done;

    int checks = 0;
    int errors = 0;
    int sb[$];
    bit prev_done = 1'b0;

    lstm_gate_mac dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
        .busy(busy), .gate_out(gate_out), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done strobe pops one expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got %0d, expected no result", $signed(gate_out));
                end else begin
                    chk("gate_out", int'($signed(gate_out)), sb.pop_front());
                end
                chk("done_width", int'(prev_done), 0);
            end
            prev_done = done;
        end
    end

    task automatic setv(input int x0, input int xr, input int w0, input int wr,
                        output int xs[8], output int ws[8]);
        for (int i = 0; i < 8; i++) begin
            xs[i] = (i == 0) ? x0 : xr;
            ws[i] = (i == 0) ? w0 : wr;
        end
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run(input string name, input int b, input int xs[8], input int ws[8],
                       input bit toggle, input bit poke, input int exp, input int exp_cyc);
        int k = 0;
        int e = 0;
        bit ph = 1'b0;
        sb.push_back(exp);
        start = 1'b1;
        bias  = 10'(b);
        @(posedge clk); e = 1; #1;
        start = 1'b0;
        chk({name, "_in_ready"}, int'(in_ready), 1);
        while (k < 8 && e < 100) begin
            in_valid = toggle ? !ph : 1'b1;
            ph       = !ph;
            x_in     = 10'(xs[k]);
            w_in     = 10'(ws[k]);
            start    = poke && (k == 3);
            @(posedge clk); e++;
            if (in_valid) k++;
            #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        while (busy && e < 100) begin
            @(posedge clk); e++; #1;
        end
        chk({name, "_busy_end"}, int'(busy), 0);
        if (exp_cyc > 0) chk({name, "_cycles"}, e, exp_cyc);
    endtask

    initial begin
        int xa[8];
        int wa[8];
        rst_n    = 1'b0;
        start    = 1'b0;
        bias     = '0;
        in_valid = 1'b0;
        x_in     = '0;
        w_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gate_out", int'(gate_out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        setv(32, 32, 16, 16, xa, wa);
        run("basic", 0, xa, wa, 1'b0, 1'b0, 128, 11);

        setv(-32, -32, 32, 32, xa, wa);
        run("neg_bias", -64, xa, wa, 1'b0, 1'b0, -320, 11);

        setv(1, 0, 16, 0, xa, wa);
        run("round_up", 0, xa, wa, 1'b0, 1'b0, 1, 11);

        setv(1, 0, 15, 0, xa, wa);
        run("round_down", 0, xa, wa, 1'b0, 1'b0, 0, 11);

        setv(511, 511, 511, 511, xa, wa);
`ifdef LSTM_GATE_MAC_SAT_EN
        run("ovf_pos", 511, xa, wa, 1'b0, 1'b0, 511, 11);
`else
        run("ovf_pos", 511, xa, wa, 1'b0, 1'b0, 255, 11);
`endif

        setv(-512, -512, 511, 511, xa, wa);
`ifdef LSTM_GATE_MAC_SAT_EN
        run("ovf_neg", 511, xa, wa, 1'b0, 1'b0, -512, 11);
`else
        run("ovf_neg", 511, xa, wa, 1'b0, 1'b0, -385, 11);
`endif

        setv(32, 32, 16, 16, xa, wa);
        run("backpressure", 0, xa, wa, 1'b1, 1'b0, 128, 18);
        run("start_in_accum", 0, xa, wa, 1'b0, 1'b1, 128, 11);

        // Reset after three accepted beats; gate_out holds 128 beforehand.
        start = 1'b1;
        bias  = '0;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        x_in     = 10'd32;
        w_in     = 10'd16;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gate_out", int'(gate_out), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("after_reset", 0, xa, wa, 1'b0, 1'b0, 128, 11);

        repeat (3) @(posedge clk);
        chk("results_outstanding", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
